glyph_serializer: RTL and testbench
===================================

Name: glyph_serializer

Overview:
Reader side of the character font ROM. Accepts character codes over a valid/ready handshake and drives the ROM's char_code/row lookup ports row by row. Each returned 8-bit font line is registered, then shifted out MSB-first as a 1-bit pixel stream with its own valid/ready handshake and row/column tags. It sits between the text buffer and the pixel/VRAM writer in the display path.

Parameters:
GLYPH_ROWS, 8, rows emitted per glyph; legal 1..16 (row port is 4 bits)

Ports:
clk  in  1  single clock; all state on rising edge
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  character code available
in_ready  out  1  block can accept a code (high only in IDLE)
in_char  in  8  character code
rom_char  out  8  char_code to font ROM (latched in_char)
rom_row  out  4  row to font ROM
rom_line  in  8  font_line from ROM (combinational, same cycle)
pix_valid  out  1  pixel available
pix_ready  in  1  downstream accepts pixel
pix_data  out  1  pixel value (1 = foreground)
pix_col  out  3  column 0..7, 0 = leftmost = font_line bit 7
pix_row  out  4  row of current pixel
pix_last_col  out  1  pix_col == 7
pix_last  out  1  last pixel of glyph (row GLYPH_ROWS-1, col 7)
busy  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync-to-clk deassert by upstream): state=IDLE, char/row/col/shift regs=0. Output values during and after reset: in_ready=1, busy=0, pix_valid=0, pix_data=0, pix_col=0, pix_row=0, pix_last_col=0, pix_last=0, rom_char=0, rom_row=0.
- States: IDLE, FETCH, SHIFT.
- IDLE: in_ready=1. On in_valid: latch in_char, set row=0, go to FETCH.
- FETCH (exactly 1 cycle): rom_char=latched char, rom_row=row. Capture rom_line into shift reg, set col=0, go to SHIFT. pix_valid=0.
- SHIFT: pix_valid=1, pix_data=shreg[7], pix_col=col, pix_row=row.
  - On pix_valid&&pix_ready: shift left (fill 0), col++.
  - If col==7: if row==GLYPH_ROWS-1, go to IDLE; else row++ and go to FETCH.
- Backpressure: while pix_valid && !pix_ready, all pix_* outputs hold stable. pix_valid never drops without a transfer.
- Latency: in_valid accepted at cycle t gives FETCH at t+1 and the first pixel at t+2. With pix_ready=1: 9 cycles per row, and IDLE is re-entered 1 cycle after the last pixel. Throughput is 1 glyph per 9*GLYPH_ROWS+1 cycles.
- rom_char/rom_row are driven from registers and are stable in all states. Only the FETCH-cycle value of rom_line is consumed.
- Unknown codes: the ROM returns 0, so all-zero pixels are emitted. There is no special casing.
- in_valid is ignored outside IDLE; no code is dropped silently because in_ready=0 there.
- Reset mid-glyph: immediate return to IDLE; the partial glyph is abandoned and no pix_last is emitted.
- Counter widths: col is 3 bits and wraps by construction. row is 4 bits and is compared against GLYPH_ROWS-1, never wraps.

Decomposition:
- Shared display package holds: GLYPH_W=8, ROW_W=4, CHAR_W=8, and the state enum {IDLE, FETCH, SHIFT}.
- No sub-module. The font ROM is instantiated beside this block at the display top level, so other readers can share the same ROM contents.

Test Plan:
- Single 'A' (0x41), pix_ready=1 -> 64 pixels. Row 0 reads 0,0,0,1,1,0,0,0. Row 4 reads 0,1,1,1,1,1,1,0. Row 7 is all 0. pix_last only on pixel 64; in_ready high again 1 cycle later; 73 cycles accept-to-accept.
- Unknown code 0x7F -> 64 zero pixels with correct pix_row/pix_col tags; pix_last_col high on every 8th pixel.
- Random pix_ready (≈50%) on 'A' -> pix_* stable while stalled; the pixel sequence is identical to the no-stall run.
- Back-to-back 'A','A' with in_valid held high -> second accept occurs exactly in the IDLE cycle after the first glyph; no pixel gap beyond the FETCH bubbles.
- rst_n pulsed low at row 3, col 4 -> outputs go to reset values asynchronously; the next 'A' restarts at row 0, col 0.
- GLYPH_ROWS=5 build -> 40 pixels per glyph; pix_last at row 4, col 7; rom_row never exceeds 4.

Source files
------------

// File: rtl/glyph_serializer_pkg.sv
// ----------------------------------------------------------------------------
// glyph_serializer_pkg
//   Shared display-path constants and the glyph serializer state encoding.
//   GLYPH_W : pixels per font line (one ROM byte)
//   ROW_W   : width of the ROM row index
//   CHAR_W  : width of a character code
//   COL_W   : width of the pixel column counter
// ----------------------------------------------------------------------------
package glyph_serializer_pkg;

    localparam int GLYPH_W = 8;
    localparam int ROW_W   = 4;
    localparam int CHAR_W  = 8;
    localparam int COL_W   = $clog2(GLYPH_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2
    } gs_state_e;

endpackage : glyph_serializer_pkg

// File: rtl/glyph_serializer.sv
// ----------------------------------------------------------------------------
// glyph_serializer
//   Reader side of the character font ROM. Takes character codes in over a
//   valid/ready handshake, walks the ROM one row at a time and shifts each
//   8-bit font line out MSB-first as a tagged 1-bit pixel stream.
//
//   Handshakes (both sides): a transfer happens on a rising edge where
//   valid && ready. A source never drops valid and never changes its payload
//   until the transfer happens; ready may be driven freely by the sink.
//   in_ready is high only in IDLE, so codes presented while busy are held
//   off, never dropped.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   in_valid/ready  character code handshake, in_char = code
//   rom_char/row    lookup address to the shared font ROM (registered)
//   rom_line        font line returned combinationally by the ROM
//   pix_valid/ready pixel handshake; pix_data = pixel (1 = foreground)
//   pix_col/row     position tags; pix_col 0 = leftmost = rom_line bit 7
//   pix_last_col    last pixel of a row
//   pix_last        last pixel of the glyph
//   busy            state != IDLE
//   dbg_state_o     current FSM state, for observation only
//
// GLYPH_ROWS: rows emitted per glyph, legal range 1..16.
// ----------------------------------------------------------------------------
module glyph_serializer
    import glyph_serializer_pkg::*;
#(
    parameter int GLYPH_ROWS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CHAR_W-1:0] in_char,
    output logic [CHAR_W-1:0] rom_char,
    output logic [ROW_W-1:0]  rom_row,
    input  logic [GLYPH_W-1:0] rom_line,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_data,
    output logic [COL_W-1:0]  pix_col,
    output logic [ROW_W-1:0]  pix_row,
    output logic              pix_last_col,
    output logic              pix_last,
    output logic              busy,
    output gs_state_e         dbg_state_o
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(GLYPH_ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(GLYPH_W - 1);

    gs_state_e           state_q, state_d;
    logic [CHAR_W-1:0]   char_q,  char_d;
    logic [ROW_W-1:0]    row_q,   row_d;
    logic [COL_W-1:0]    col_q,   col_d;
    logic [GLYPH_W-1:0]  shreg_q, shreg_d;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            char_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            char_q  <= char_d;
            row_q   <= row_d;
            col_q   <= col_d;
            shreg_q <= shreg_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        char_d  = char_q;
        row_d   = row_q;
        col_d   = col_q;
        shreg_d = shreg_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    char_d  = in_char;
                    row_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // rom_char/rom_row have been stable since the previous edge,
                // so rom_line is valid for the whole of this cycle.
                shreg_d = rom_line;
                col_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (pix_ready) begin
                    shreg_d = {shreg_q[GLYPH_W-2:0], 1'b0};
                    // col wraps 7 -> 0 on its own; FETCH also clears it.
                    col_d   = col_q + COL_W'(1);
                    if (col_q == LAST_COL) begin
                        if (row_q == LAST_ROW) begin
                            state_d = IDLE;
                        end else begin
                            row_d   = row_q + ROW_W'(1);
                            state_d = FETCH;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: all decoded from registers, so the pixel side holds
    // steady through any stall and the ROM address never glitches.
    // Pixel tags are zeroed outside SHIFT so idle/reset values are clean.
    // ------------------------------------------------------------------
    logic in_shift;
    assign in_shift     = (state_q == SHIFT);

    assign in_ready     = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign dbg_state_o  = state_q;

    assign rom_char     = char_q;
    assign rom_row      = row_q;

    assign pix_valid    = in_shift;
    assign pix_data     = in_shift & shreg_q[GLYPH_W-1];
    assign pix_col      = in_shift ? col_q : '0;
    assign pix_row      = in_shift ? row_q : '0;
    assign pix_last_col = in_shift && (col_q == LAST_COL);
    assign pix_last     = in_shift && (col_q == LAST_COL) && (row_q == LAST_ROW);

endmodule : glyph_serializer

// File: tb/tb_glyph_serializer.sv
// ----------------------------------------------------------------------------
// tb_glyph_serializer
//   Two serializer instances (8-row and 5-row builds) each fed by a small
//   behavioural font ROM. Expected pixel streams are built from the glyph
//   bitmaps row by row into exp_q and compared on every pixel transfer.
// ----------------------------------------------------------------------------
module tb_glyph_serializer;
    import glyph_serializer_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- shared stimulus ----------------
    logic       in_valid;
    logic [7:0] in_char;
    logic       pix_ready;
    bit         sel;          // 0 = 8-row DUT, 1 = 5-row DUT

    // ---------------- behavioural font ROM ----------------
    function automatic logic [7:0] font(input logic [7:0] c, input logic [3:0] r);
        logic [7:0] line;
        line = 8'h00;
        if (c == 8'h41) begin          // 'A'
            case (r)
                4'd0: line = 8'h18;
                4'd1: line = 8'h3C;
                4'd2, 4'd3, 4'd5, 4'd6: line = 8'h66;
                4'd4: line = 8'h7E;
                default: line = 8'h00;
            endcase
        end else if (c == 8'h42) begin // 'B'
            case (r)
                4'd0, 4'd3, 4'd6: line = 8'h7C;
                4'd1, 4'd2, 4'd4, 4'd5: line = 8'h66;
                default: line = 8'h00;
            endcase
        end
        return line;
    endfunction

    // ---------------- DUT A (8 rows) ----------------
    logic       a_in_valid, a_in_ready, a_pix_valid, a_pix_data, a_last_col, a_last, a_busy;
    logic [7:0] a_rom_char, a_rom_line;
    logic [3:0] a_rom_row, a_pix_row;
    logic [2:0] a_pix_col;
    gs_state_e  a_dbg;
    assign a_in_valid = in_valid & ~sel;
    assign a_rom_line = font(a_rom_char, a_rom_row);

    glyph_serializer #(.GLYPH_ROWS(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_char(in_char),
        .rom_char(a_rom_char), .rom_row(a_rom_row), .rom_line(a_rom_line),
        .pix_valid(a_pix_valid), .pix_ready(pix_ready), .pix_data(a_pix_data),
        .pix_col(a_pix_col), .pix_row(a_pix_row),
        .pix_last_col(a_last_col), .pix_last(a_last),
        .busy(a_busy), .dbg_state_o(a_dbg)
    );

    // ---------------- DUT B (5 rows) ----------------
    logic       b_in_valid, b_in_ready, b_pix_valid, b_pix_data, b_last_col, b_last, b_busy;
    logic [7:0] b_rom_char, b_rom_line;
    logic [3:0] b_rom_row, b_pix_row;
    logic [2:0] b_pix_col;
    gs_state_e  b_dbg;
    assign b_in_valid = in_valid & sel;
    assign b_rom_line = font(b_rom_char, b_rom_row);

    glyph_serializer #(.GLYPH_ROWS(5)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_char(in_char),
        .rom_char(b_rom_char), .rom_row(b_rom_row), .rom_line(b_rom_line),
        .pix_valid(b_pix_valid), .pix_ready(pix_ready), .pix_data(b_pix_data),
        .pix_col(b_pix_col), .pix_row(b_pix_row),
        .pix_last_col(b_last_col), .pix_last(b_last),
        .busy(b_busy), .dbg_state_o(b_dbg)
    );

    // ---------------- selected-DUT view ----------------
    logic       m_in_ready, m_pix_valid, m_pix_data, m_last_col, m_last;
    logic [2:0] m_col;
    logic [3:0] m_row, m_rom_row;
    assign m_in_ready  = sel ? b_in_ready  : a_in_ready;
    assign m_pix_valid = sel ? b_pix_valid : a_pix_valid;
    assign m_pix_data  = sel ? b_pix_data  : a_pix_data;
    assign m_last_col  = sel ? b_last_col  : a_last_col;
    assign m_last      = sel ? b_last      : a_last;
    assign m_col       = sel ? b_pix_col   : a_pix_col;
    assign m_row       = sel ? b_pix_row   : a_pix_row;
    assign m_rom_row   = sel ? b_rom_row   : a_rom_row;

    // ---------------- scoreboard ----------------
    logic [9:0] exp_q[$];      // {data, col[2:0], row[3:0], last_col, last}
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected stream of one glyph: every row, left to right.
    task automatic push_glyph(input logic [7:0] c, input int rows);
        logic [7:0] line;
        for (int r = 0; r < rows; r++) begin
            line = font(c, 4'(r));
            for (int col = 0; col < 8; col++) begin
                exp_q.push_back({line[7-col], 3'(col), 4'(r), col == 7,
                                 (r == rows - 1) && (col == 7)});
            end
        end
    endtask

    // ---------------- driver ----------------
    logic [7:0] chars[4];
    int acc_edge[4];
    int last_edge[4];
    int pix_cnt, ones_cnt;
    logic [3:0] max_rom_row;

    // Offer n codes back-to-back (in_valid held), drain all pixels with
    // pix_ready low stall_pct percent of the time.
    task automatic run_glyphs(input int n, input int stall_pct);
        int n_acc = 0;
        int n_done = 0;
        int guard = 0;
        bit prev_stall = 0;
        bit chk_idle = 0;
        logic [9:0] snap = '0;
        logic [9:0] cur, exp;
        pix_cnt = 0;
        ones_cnt = 0;
        while (n_acc < n || n_done < n || chk_idle) begin
            @(negedge clk);
            guard++;
            if (guard > 3000) begin
                n_vec++; n_err++;
                $display("FAIL run_timeout: accepted %0d done %0d, expected %0d", n_acc, n_done, n);
                break;
            end
            cur = {m_pix_data, m_col, m_row, m_last_col, m_last};
            if (m_rom_row > max_rom_row) max_rom_row = m_rom_row;
            if (chk_idle) begin
                check("ready_after_last", {31'd0, m_in_ready}, 32'd1);
                chk_idle = 0;
            end
            if (prev_stall) check("stall_hold", {m_pix_valid, cur}, {1'b1, snap});
            // input side
            in_valid = (n_acc < n);
            in_char  = chars[(n_acc < n) ? n_acc : 0];
            if (in_valid && m_in_ready) begin
                acc_edge[n_acc] = cyc + 1;
                push_glyph(in_char, sel ? 5 : 8);
                n_acc++;
            end
            // output side
            pix_ready = ($urandom_range(0, 99) >= stall_pct);
            if (m_pix_valid && pix_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL extra_pixel: got 0x%0h, expected none", cur);
                end else begin
                    exp = exp_q.pop_front();
                    check("pixel", {22'd0, cur}, {22'd0, exp});
                end
                pix_cnt++;
                ones_cnt += int'(m_pix_data);
                if (m_last) begin
                    if (n_done < 4) last_edge[n_done] = cyc + 1;
                    n_done++;
                    chk_idle = 1;
                end
            end
            prev_stall = m_pix_valid && !pix_ready;
            snap = cur;
        end
        in_valid = 1'b0;
        check("exp_q_drained", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    task automatic check_a_reset(input string tag);
        check({tag, "_in_ready"}, {31'd0, a_in_ready}, 32'd1);
        check({tag, "_busy"}, {31'd0, a_busy}, 32'd0);
        check({tag, "_pix"}, {a_pix_valid, a_pix_data, a_pix_col, a_pix_row, a_last_col, a_last}, 32'd0);
        check({tag, "_rom"}, {a_rom_char, a_rom_row}, 32'd0);
        check({tag, "_state"}, {30'd0, a_dbg}, {30'd0, IDLE});
    endtask

    // ---------------- stimulus table ----------------
    typedef struct {
        logic [7:0] ch;
        int         stall_pct;
        bit         use_b;
        int         exp_pix;
        int         exp_ones;
        int         exp_lat;      // accept edge -> last-pixel edge, -1 if stalled
        int         exp_max_row;
    } vec_t;

    vec_t tab[6];

    initial begin
        tab[0] = '{8'h41,  0, 1'b0, 64, 28, 72, 7};
        tab[1] = '{8'h7F,  0, 1'b0, 64,  0, 72, 7};
        tab[2] = '{8'h41, 50, 1'b0, 64, 28, -1, 7};
        tab[3] = '{8'h42,  0, 1'b0, 64, 31, 72, 7};
        tab[4] = '{8'h41,  0, 1'b1, 40, 20, 45, 4};
        tab[5] = '{8'h42, 30, 1'b1, 40, 22, -1, 4};

        rst_n = 1'b0; in_valid = 1'b0; in_char = 8'h00; pix_ready = 1'b0; sel = 1'b0;
        repeat (3) @(negedge clk);
        check_a_reset("reset");
        check("reset_b", {b_in_ready, b_busy, b_pix_valid, b_rom_row}, {1'b1, 1'b0, 1'b0, 4'd0});
        rst_n = 1'b1;
        @(negedge clk);
        check_a_reset("post_reset");

        // table-driven single glyphs
        for (int i = 0; i < 6; i++) begin
            sel = tab[i].use_b;
            chars[0] = tab[i].ch;
            max_rom_row = 4'd0;
            run_glyphs(1, tab[i].stall_pct);
            check("pix_count", pix_cnt, tab[i].exp_pix);
            check("ones_count", ones_cnt, tab[i].exp_ones);
            check("max_rom_row", {28'd0, max_rom_row}, tab[i].exp_max_row);
            if (tab[i].exp_lat >= 0) check("glyph_latency", last_edge[0] - acc_edge[0], tab[i].exp_lat);
        end

        // back-to-back 'A','A' on the 8-row build: 73 edges accept-to-accept
        sel = 1'b0;
        chars[0] = 8'h41; chars[1] = 8'h41;
        run_glyphs(2, 0);
        check("b2b_accept_gap", acc_edge[1] - acc_edge[0], 32'd73);
        check("b2b_second_lat", last_edge[1] - acc_edge[1], 32'd72);
        check("b2b_pix_count", pix_cnt, 32'd128);

        // back-to-back on the 5-row build
        sel = 1'b1;
        chars[0] = 8'h42; chars[1] = 8'h7F;
        max_rom_row = 4'd0;
        run_glyphs(2, 0);
        check("b2b5_accept_gap", acc_edge[1] - acc_edge[0], 32'd46);
        check("b2b5_max_rom_row", {28'd0, max_rom_row}, 32'd4);

        // reset in the middle of a glyph at row 3, col 4
        begin
            bit hit = 0;
            bit seen_last = 0;
            sel = 1'b0; pix_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b1; in_char = 8'h41;
            @(negedge clk);
            in_valid = 1'b0;
            for (int i = 0; i < 200; i++) begin
                if (a_last) seen_last = 1;
                if (a_pix_valid && a_pix_row == 4'd3 && a_pix_col == 3'd4) begin
                    hit = 1;
                    break;
                end
                @(negedge clk);
            end
            check("abort_reached_r3c4", {31'd0, hit}, 32'd1);
            check("abort_no_last", {31'd0, seen_last}, 32'd0);
            #2 rst_n = 1'b0;
            #1 check_a_reset("async_reset");
            @(negedge clk);
            rst_n = 1'b1;
            chars[0] = 8'h41;
            run_glyphs(1, 0);
            check("restart_pix_count", pix_cnt, 32'd64);
        end

        // randomized glyph sequences against the bitmap model
        for (int k = 0; k < 12; k++) begin
            int n;
            int stall;
            sel = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 3);
            stall = $urandom_range(0, 70);
            for (int j = 0; j < n; j++) begin
                case ($urandom_range(0, 3))
                    0: chars[j] = 8'h41;
                    1: chars[j] = 8'h42;
                    2: chars[j] = 8'h20;
                    default: chars[j] = 8'($urandom_range(0, 255));
                endcase
            end
            run_glyphs(n, stall);
            check("rand_pix_count", pix_cnt, n * 8 * (sel ? 5 : 8));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_glyph_serializer
